// File: rtl/stream_fill_ctrl.sv
// stream_fill_ctrl: accepts a len_i-word burst over valid/ready, drives the external address
// counter and issues registered memory writes at the counter address.
module stream_fill_ctrl #(
    parameter int CNT_WIDTH  = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    input  logic                  abort_i,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    input  logic [CNT_WIDTH-1:0]  cnt_i,
    output logic                  cnt_en_o,
    output logic                  cnt_done_o,
    output logic                  mem_we_o,
    output logic [CNT_WIDTH-1:0]  mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    state_t                state_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic                  aborted_q;
    logic                  hs;
    logic                  last;
    assign s_ready_o   = state_q == FILL;
    assign hs          = s_ready_o && s_valid_i;
    // Equality on len_q-1 lets a full 2^CNT_WIDTH-1 burst end without counter wrap.
    assign last        = hs && (cnt_i == len_q - 1'b1);
    assign cnt_en_o    = hs;
    assign cnt_done_o  = state_q == DONE;
    assign done_o      = state_q == DONE;
    assign busy_o      = state_q != IDLE;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign aborted_o   = aborted_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            we_q <= hs;
            if (hs) begin
                addr_q  <= cnt_i;
                wdata_q <= s_data_i;
            end
            case (state_q)
                IDLE: if (start_i) begin
                    len_q     <= len_i;
                    aborted_q <= 1'b0;
                    state_q   <= (len_i == '0) ? DONE : FILL;
                end
                FILL: if (last) begin
                    aborted_q <= 1'b0;
                    state_q   <= DONE;
                end else if (abort_i) begin
                    aborted_q <= 1'b1;
                    state_q   <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_fill_ctrl.sv
// tb_stream_fill_ctrl: burst-level scoreboard for stream_fill_ctrl with an external counter model.
module tb_stream_fill_ctrl;
    logic        clk, rst, start_i, abort_i, s_valid_i;
    logic [6:0]  len_i, cnt;
    logic [31:0] s_data_i;
    logic        s_ready_o, cnt_en_o, cnt_done_o, mem_we_o, busy_o, done_o, aborted_o;
    logic [6:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    int          checks = 0, errors = 0;
    int          ndone, nrdy, nen, nboth;
    logic [38:0] got[$];
    logic [31:0] exp_q[$];

    stream_fill_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i), .abort_i(abort_i),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o), .cnt_i(cnt),
        .cnt_en_o(cnt_en_o), .cnt_done_o(cnt_done_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .busy_o(busy_o),
        .done_o(done_o), .aborted_o(aborted_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // The address counter this block controls
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (cnt_done_o) cnt <= '0;
        else if (cnt_en_o) cnt <= cnt + 1'b1;

    always @(negedge clk) if (!rst) begin
        if (mem_we_o) got.push_back({mem_addr_o, mem_wdata_o});
        if (done_o) ndone++;
        if (s_ready_o) nrdy++;
        if (cnt_en_o) nen++;
        if (cnt_en_o && cnt_done_o) nboth++;
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_outs"}, {s_ready_o, cnt_en_o, cnt_done_o, mem_we_o, busy_o, done_o, aborted_o}, 0);
    endtask

    // ab: beats accepted before abort; co: abort rides on beat ab; vm: 0 solid, 1 toggle, 2 random
    task automatic burst(input int L, input int ab, input bit co, input int vm,
                         input logic [31:0] db, input bit noise);
        int  n, b, fillc, cyc;
        bit  stop, v, a;
        n = (ab >= 0 && ab < L) ? (co ? ab + 1 : ab) : L;
        got.delete(); exp_q.delete();
        ndone = 0; nrdy = 0; nen = 0; nboth = 0;
        start_i = 1; len_i = 7'(L); abort_i = 0; s_valid_i = 0;
        tick();
        start_i = 0;
        b = 0; fillc = 0; cyc = 0; stop = (L == 0);
        while (!stop && cyc < 2000) begin
            a = 0;
            if (b == ab && co) begin v = 1; a = 1; end
            else if (b == ab && !co) begin v = 0; a = 1; end
            else v = (vm == 0) ? 1'b1 : (vm == 1) ? (fillc % 2 == 0) : 1'($urandom_range(0, 1));
            s_valid_i = v; abort_i = a; s_data_i = db + 32'(b);
            if (noise) begin start_i = 1'($urandom_range(0, 1)); len_i = 7'($urandom); end
            #1;
            chk("fill_ready", s_ready_o, 1);
            chk("fill_cnt_en", cnt_en_o, v);
            if (v) begin exp_q.push_back(s_data_i); b++; end
            fillc++; cyc++;
            tick();
            stop = a || b == L;
        end
        if (!stop) chk("fill_timeout", 0, 1);
        s_valid_i = 1'($urandom_range(0, 1)); abort_i = noise; start_i = noise; len_i = 7'($urandom);
        #1;
        chk("done_pulse", {done_o, cnt_done_o, busy_o, s_ready_o, cnt_en_o}, 5'b11100);
        chk("done_aborted", aborted_o, n < L);
        tick();
        start_i = 0; abort_i = 0; s_valid_i = 0;
        chk("post_idle", {busy_o, done_o, cnt_done_o, s_ready_o}, 0);
        tick();
        chk("n_writes", got.size(), n);
        for (int i = 0; i < n && i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("wr%0d", i), got[i], {7'(i), exp_q[i]});
        chk("n_done", ndone, 1);
        chk("n_ready", nrdy, fillc);
        chk("n_cnt_en", nen, n);
        chk("en_done_excl", nboth, 0);
    endtask

    initial begin
        rst = 1; start_i = 0; len_i = 0; abort_i = 0; s_valid_i = 0; s_data_i = 0;
        #1;
        idle_outputs("in_reset");
        tick(); tick();
        rst = 0;
        tick();
        idle_outputs("after_reset");
        chk("reset_addr_data", {mem_addr_o, mem_wdata_o}, 0);
        burst(4, -1, 0, 0, 32'hA0, 0);
        burst(100, -1, 0, 1, $urandom, 0);
        burst(0, -1, 0, 0, 0, 0);
        burst(10, 3, 0, 2, $urandom, 0);
        burst(10, 4, 1, 0, $urandom, 0);
        burst(3, 2, 1, 1, $urandom, 0);
        burst(127, -1, 0, 2, $urandom, 0);
        burst(6, -1, 0, 2, $urandom, 1);
        // Reset in the middle of a burst
        start_i = 1; len_i = 10;
        tick();
        start_i = 0; s_valid_i = 1; s_data_i = 32'h55;
        tick(); tick();
        #2 rst = 1;
        #1;
        idle_outputs("mid_rst");
        chk("mid_rst_addr_data", {mem_addr_o, mem_wdata_o}, 0);
        s_valid_i = 0;
        tick();
        rst = 0;
        tick();
        idle_outputs("mid_rst_release");
        burst(2, -1, 0, 0, 32'hC0, 0);
        for (int k = 0; k < 20; k++) begin
            int L, ab;
            L = $urandom_range(0, 40);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, L)) : -1;
            burst(L, ab, 1'($urandom_range(0, 1)), 2, $urandom, 1'($urandom_range(0, 1)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_fill_ctrl.md
Name: stream_fill_ctrl

Overview:
- Upstream controller for the address counter.
- Accepts a burst of `len_i` data words over a valid/ready stream.
- Drives the counter's increment (`cnt_en_o`) and clear (`cnt_done_o`) controls, and reads the counter value back on `cnt_i` as the write address.
- Issues registered write strobes to the buffer memory (100-entry class), then signals completion to the top-level sequencer.

Parameters:
- CNT_WIDTH, 7, width of counter/address and of `len_i`; max burst = 2^CNT_WIDTH-1.
- DATA_WIDTH, 32, width of stream and memory write data.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  one-cycle request to begin a burst; honoured only in IDLE
- len_i  input  CNT_WIDTH  burst length, sampled when start_i accepted
- abort_i  input  1  terminate burst early; honoured only in FILL
- s_valid_i  input  1  stream data valid
- s_data_i  input  DATA_WIDTH  stream data
- s_ready_o  output  1  stream ready
- cnt_i  input  CNT_WIDTH  current count from address counter
- cnt_en_o  output  1  counter increment strobe
- cnt_done_o  output  1  counter clear strobe
- mem_we_o  output  1  memory write enable (registered)
- mem_addr_o  output  CNT_WIDTH  memory write address (registered)
- mem_wdata_o  output  DATA_WIDTH  memory write data (registered)
- busy_o  output  1  high in FILL and DONE
- done_o  output  1  one-cycle completion pulse
- aborted_o  output  1  valid with done_o; 1 = burst ended by abort_i

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; FSM = IDLE; `len_q` = 0; write pipeline cleared. Reset asserted mid-burst returns to IDLE immediately; no further writes.
- States: IDLE, FILL, DONE.
- IDLE:
  - `s_ready_o`=0.
  - `start_i`=1 latches `len_q` = `len_i`.
  - If `len_i`=0 go to DONE (zero-length burst, `aborted_o`=0); else go to FILL.
- FILL:
  - `s_ready_o`=1 combinationally.
  - Handshake = `s_valid_i` & `s_ready_o`.
  - On handshake, `cnt_en_o`=1 in the same cycle (combinational).
  - On handshake, the pipeline register captures `mem_addr_o` = `cnt_i`, `mem_wdata_o` = `s_data_i` and `mem_we_o`=1 at the next edge. Write latency is 1 cycle after the handshake.
  - `mem_we_o` is 0 in any cycle not following a handshake; the address/data registers hold their last values.
  - Handshake with `cnt_i` == `len_q`-1 → DONE, `aborted_o`=0.
  - `abort_i`=1 → DONE, `aborted_o`=1.
  - `abort_i` and a handshake in the same cycle: the beat is accepted and written (`cnt_en_o`=1, write issued), then DONE with `aborted_o`=1, unless that beat was the last, in which case `aborted_o`=0.
- DONE (exactly 1 cycle):
  - `s_ready_o`=0, `cnt_en_o`=0, `cnt_done_o`=1, `done_o`=1, `aborted_o` as latched; next state IDLE.
  - The final write issued by the last handshake is presented in this same cycle.
- `cnt_en_o` and `cnt_done_o` are never asserted together.
- `busy_o`=1 in FILL and DONE.
- `start_i` outside IDLE is ignored. `abort_i` outside FILL is ignored.
- `s_valid_i` may deassert at any time in FILL (stall). The FSM holds indefinitely; no timeout.
- `cnt_i` is trusted. The end comparison uses equality only, so `len_q` up to 2^CNT_WIDTH-1 works without wrap.
- `aborted_o` is held until the next start; it is meaningful only while `done_o`=1.

Test Plan:
- Reset, then `start_i` with `len_i`=4 and `s_valid_i` held 1, data 0xA0..0xA3 → `cnt_en_o` high for 4 cycles; `mem_we_o` at addr 0..3 with 0xA0..0xA3, each 1 cycle after its handshake; `done_o` and `cnt_done_o` pulse once; back in IDLE.
- `len_i`=100 with `s_valid_i` toggling every other cycle → exactly 100 writes to addr 0..99 in order, no gaps in address, `done_o` after last; `cnt_en_o` count = 100.
- `len_i`=0 → next cycle DONE: `done_o`=1, `cnt_done_o`=1, no `mem_we_o`, `s_ready_o` never 1.
- `abort_i` after 3 beats of `len_i`=10 → 3 writes (addr 0..2), `done_o`=1 with `aborted_o`=1; abort coincident with a handshake on the 5th beat → 5 writes, `aborted_o`=1.
- `rst` asserted mid-FILL after 2 beats → all outputs 0 asynchronously, state IDLE; a new `start_i` with `len_i`=2 after reset completes normally.
- `start_i` pulsed during FILL and DONE → ignored; burst length unchanged; no extra `done_o`.
